des_key_trojan_ctrl: RTL and testbench
======================================

# des_key_trojan_ctrl

Sequential trigger controller and key-delivery stage for the 56-bit DES key path. Keys enter over a valid/ready handshake and leave through a one-entry output register. A sequence-trigger FSM watches the 32-bit trigger bus. After MATCH_COUNT consecutive matching trigger words it XORs FLIP_MASK into the next HOLD_KEYS delivered keys, then re-arms. It sits between the key source and the DES core key input.

## Interface
Parameters:
- TRIG_VALUE, 4'h5: value compared against trigger[3:0].
- MATCH_COUNT, 3: consecutive matching trigger words needed to activate (1..255).
- HOLD_KEYS, 2: number of accepted keys modified per activation (1..255).
- FLIP_MASK, 56'h1: XOR mask applied to modified keys.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- key_in, input, 56: key from source.
- key_valid, input, 1: key_in valid.
- key_ready, output, 1: stage can accept key_in.
- trigger, input, 32: trigger word.
- trig_valid, input, 1: trigger word valid this cycle.
- key_out, output, 56: key to DES core.
- key_out_valid, output, 1: key_out valid.
- key_out_ready, input, 1: DES core accepts key_out.
- active, output, 1: FSM in ACTIVE.
- match_cnt, output, 8: current consecutive-match count.
- disarm, input, 1: present only with DES_TROJAN_DISARM_EN.

## Operation
- A match is trig_valid=1 and trigger[3:0]==TRIG_VALUE. Bits 31:4 are ignored. A mismatch is trig_valid=1 with any other nibble.
- FSM states are IDLE, COUNT and ACTIVE.
- IDLE:
  - On a match, match_cnt<=1. Go to ACTIVE if MATCH_COUNT==1, else go to COUNT.
- COUNT:
  - On a match, match_cnt++. When the new count equals MATCH_COUNT, go to ACTIVE.
  - On a mismatch, match_cnt<=0 and go to IDLE.
  - With trig_valid=0, hold state and count (gaps do not break the sequence).
- ACTIVE:
  - Trigger bus is ignored.
  - keys_left loads HOLD_KEYS on entry and decrements on each key acceptance.
  - The acceptance that brings keys_left to 0 returns the FSM to IDLE with match_cnt<=0.
- Key stage:
  - key_ready = !key_out_valid || key_out_ready.
  - Acceptance is key_valid && key_ready.
  - On acceptance, key_out <= key_in ^ FLIP_MASK if the registered state is ACTIVE, else key_in. key_out_valid<=1.
  - If there is no acceptance and key_out_ready=1, key_out_valid<=0.
- key_out holds stable while key_out_valid=1 and key_out_ready=0.

## Timing
- Reset values: key_out=0, key_out_valid=0, active=0, match_cnt=0, state IDLE, keys_left=0. key_ready=1 after reset.
- Key latency is 1 cycle, input acceptance to key_out_valid. Full throughput is one key per cycle when key_out_ready=1.
- Trigger-to-active latency: active rises the cycle after the final matching trigger is sampled.
- Simultaneous events:
  - Final match and key acceptance in the same cycle: that key is NOT modified; the first modified key is the next one accepted.
  - Last ACTIVE acceptance: that key IS modified; active falls the next cycle.
  - A trigger match in that same cycle is ignored.
- Backpressure does not consume keys_left. Only acceptances count.
- Asserting rst_n low mid-operation immediately clears all state. A held output key is discarded.

## Configuration
- DES_TROJAN_DISARM_EN defined:
  - Adds the disarm input.
  - disarm=1 forces the FSM to IDLE, match_cnt<=0 and keys_left<=0 on the next edge, taking priority over all transitions.
  - The key accepted in that same cycle still uses the pre-edge state.
- DES_TROJAN_DISARM_EN undefined: no disarm port; behaviour is as above.

## Structure
- Package des_trojan_pkg holds:
  - KEY_W=56 and TRIG_W=32.
  - The state enum (IDLE, COUNT, ACTIVE).
  - The match-nibble width of 4.
- Sub-module des_trojan_trigger_fsm holds the state, match_cnt and keys_left. It takes trig_valid, trigger[3:0] and the accept strobe, and outputs active.
- The top level holds the key register and the handshake.

## Test plan
- Reset: hold rst_n=0 with random inputs. key_out_valid=0, key_out=0, active=0, match_cnt=0; key_ready=1 after release.
- Activation: triggers 5,5,5 on consecutive valid cycles, then keys 56'hAA and 56'hAB and 56'hAC. active rises after the third trigger; outputs are 56'hAB and 56'hAA, then 56'hAC unmodified, and active falls after the second key.
- Sequence break: triggers 5,5,7,5. match_cnt goes 1,2,0,1 and active stays 0. A trigger gap (trig_valid=0) between 5s still reaches activation.
- Upper-bit ignore: trigger 32'hFFFF_FFF5 ×3 activates. Trigger 32'h0000_0015 counts as a match; 32'h0000_0050 does not.
- Backpressure: while ACTIVE, hold key_out_ready=0 for 4 cycles. key_out stays stable, key_ready=0, keys_left is unchanged, and the next two accepted keys are still modified.
- Same-cycle edge: the third match and key 56'h10 in the same cycle. Output is 56'h10 unmodified; the following key 56'h20 outputs 56'h21.

Source files
------------

// File: rtl/des_trojan_pkg.sv
// Shared widths, trigger FSM state encoding and the trigger-nibble match helper
// for the DES key-delivery trigger controller.
package des_trojan_pkg;

  localparam int KEY_W = 56;
  localparam int TRIG_W = 32;
  localparam int NIB_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } trig_state_e;

  function automatic logic nib_match(input logic valid, input logic [NIB_W-1:0] nib,
                                     input logic [NIB_W-1:0] ref_nib);
    return valid && (nib == ref_nib);
  endfunction

endpackage

// File: rtl/des_trojan_trigger_fsm.sv
// Sequence-trigger FSM: counts consecutive matching trigger nibbles and holds
// the modify window open for HOLD_KEYS accepted keys. Optional DES_TROJAN_DISARM_EN.
import des_trojan_pkg::*;

module des_trojan_trigger_fsm #(
  parameter logic [NIB_W-1:0] TRIG_VALUE  = 4'h5,
  parameter int               MATCH_COUNT = 3,
  parameter int               HOLD_KEYS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_valid,
  input  logic [NIB_W-1:0] trig_nib,
  input  logic             accept,
`ifdef DES_TROJAN_DISARM_EN
  input  logic             disarm,
`endif
  output logic             active,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_COUNT  = ST_COUNT;
  localparam logic [1:0] S_ACTIVE = ST_ACTIVE;
  localparam logic [CNT_W-1:0] MATCH_TGT = CNT_W'(MATCH_COUNT);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_KEYS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             match_s;
  logic             miss_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    match_s = nib_match(trig_valid, trig_nib, TRIG_VALUE);
    miss_s  = trig_valid && !match_s;
    case (state_q)
      S_IDLE: begin
        if (match_s) begin
          cnt_d = 8'd1;
          if (MATCH_TGT == 8'd1) begin
            state_d = S_ACTIVE;
            left_d  = HOLD_LD;
          end else begin
            state_d = S_COUNT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (match_s) begin
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == MATCH_TGT) begin
            state_d = S_ACTIVE;
            left_d  = HOLD_LD;
          end else begin
            state_d = S_COUNT;
          end
        end else if (miss_s) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_ACTIVE: begin
        // Trigger bus is ignored here; only key acceptances drain the window.
        if (accept) begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_ACTIVE;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        left_d  = 8'd0;
      end
    endcase
`ifdef DES_TROJAN_DISARM_EN
    if (disarm) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      left_d  = 8'd0;
    end else begin
      state_d = state_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      left_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
    end
  end

  assign active    = (state_q == S_ACTIVE);
  assign match_cnt = cnt_q;

endmodule

// File: rtl/des_key_trojan_ctrl.sv
// Key-delivery stage: one-entry output register with valid/ready handshake,
// XORing FLIP_MASK into keys accepted while the trigger FSM is ACTIVE. Optional DES_TROJAN_DISARM_EN.
import des_trojan_pkg::*;

module des_key_trojan_ctrl #(
  parameter logic [NIB_W-1:0] TRIG_VALUE  = 4'h5,
  parameter int               MATCH_COUNT = 3,
  parameter int               HOLD_KEYS   = 2,
  parameter logic [KEY_W-1:0] FLIP_MASK   = 56'h1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              trig_valid,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_out_valid,
  input  logic              key_out_ready,
`ifdef DES_TROJAN_DISARM_EN
  input  logic              disarm,
`endif
  output logic              active,
  output logic [CNT_W-1:0]  match_cnt
);

  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_out_valid_q, key_out_valid_d;
  logic             accept_s;
  logic             trig_unused_s;

  assign key_ready     = !key_out_valid_q || key_out_ready;
  assign accept_s      = key_valid && key_ready;
  assign trig_unused_s = ^trigger[TRIG_W-1:NIB_W];

  des_trojan_trigger_fsm #(
    .TRIG_VALUE  (TRIG_VALUE),
    .MATCH_COUNT (MATCH_COUNT),
    .HOLD_KEYS   (HOLD_KEYS)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_valid (trig_valid),
    .trig_nib   (trigger[NIB_W-1:0]),
    .accept     (accept_s),
`ifdef DES_TROJAN_DISARM_EN
    .disarm     (disarm),
`endif
    .active     (active),
    .match_cnt  (match_cnt)
  );

  // Modification uses the pre-edge FSM state, so a same-cycle final match leaves this key clean.
  always_comb begin
    key_out_d       = key_out_q;
    key_out_valid_d = key_out_valid_q;
    if (accept_s) begin
      key_out_d       = active ? (key_in ^ FLIP_MASK) : key_in;
      key_out_valid_d = 1'b1;
    end else if (key_out_ready) begin
      key_out_valid_d = 1'b0;
    end else begin
      key_out_valid_d = key_out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out_q       <= 56'h0;
      key_out_valid_q <= 1'b0;
    end else begin
      key_out_q       <= key_out_d;
      key_out_valid_q <= key_out_valid_d;
    end
  end

  assign key_out       = key_out_q;
  assign key_out_valid = key_out_valid_q;

endmodule

// File: tb/tb_des_key_trojan_ctrl.sv
// Self-checking bench for des_key_trojan_ctrl with default parameters
// (TRIG_VALUE=5, MATCH_COUNT=3, HOLD_KEYS=2, FLIP_MASK=1).
`timescale 1ns/1ps

module tb_des_key_trojan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [55:0] key_in;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] trigger;
  logic        trig_valid;
  logic [55:0] key_out;
  logic        key_out_valid;
  logic        key_out_ready;
  logic        active;
  logic [7:0]  match_cnt;
`ifdef DES_TROJAN_DISARM_EN
  logic        disarm = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: matches seen so far, modified keys still owed, output register.
  int          m_cnt;
  int          m_left;
  logic [55:0] m_out;
  logic        m_valid;

  always #5 clk = ~clk;

  des_key_trojan_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .trigger       (trigger),
    .trig_valid    (trig_valid),
    .key_out       (key_out),
    .key_out_valid (key_out_valid),
    .key_out_ready (key_out_ready),
`ifdef DES_TROJAN_DISARM_EN
    .disarm        (disarm),
`endif
    .active        (active),
    .match_cnt     (match_cnt)
  );

  task automatic model_clear();
    m_cnt = 0; m_left = 0; m_out = 56'h0; m_valid = 1'b0;
  endtask

  // Drive one cycle at the falling edge, advance the model, land on the next falling edge.
  task automatic step(input logic kv, input logic [55:0] k, input logic tv,
                      input logic [31:0] t, input logic kor);
    logic rdy, acc;
    key_valid = kv; key_in = k; trig_valid = tv; trigger = t; key_out_ready = kor;
    rdy = !m_valid || kor;
    acc = kv && rdy;
    if (acc) begin
      m_out = (m_left > 0) ? (k ^ 56'h1) : k;
      m_valid = 1'b1;
    end else if (kor) begin
      m_valid = 1'b0;
    end
    if (m_left > 0) begin
      if (acc) begin
        m_left--;
        if (m_left == 0) m_cnt = 0;
      end
    end else if (tv) begin
      if (t[3:0] == 4'h5) begin
        m_cnt++;
        if (m_cnt == 3) m_left = 2;
      end else begin
        m_cnt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_valid = 1'b0; key_in = 56'h0; trig_valid = 1'b0; trigger = 32'h0; key_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'($urandom); key_in = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
      trig_valid = 1'($urandom); trigger = $urandom; key_out_ready = 1'($urandom);
      @(negedge clk);
      n_vec++;
      if (key_out_valid !== 1'b0 || key_out !== 56'h0 || active !== 1'b0 || match_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL reset_hold: got valid=%b out=%h active=%b cnt=%0d, want 0/0/0/0",
                 key_out_valid, key_out, active, match_cnt);
      end
    end
    key_valid = 1'b0; trig_valid = 1'b0; key_out_ready = 1'b0;
    rst_n = 1'b1;
    model_clear();
    #1;
    if (key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got key_ready=%b want 1", key_ready);
    end
    // Mid-operation reset drops a held output key immediately.
    @(negedge clk);
    step(1'b1, 56'h12_3456_789A_BCDE, 1'b1, 32'h5, 1'b0);
    if (key_out_valid !== 1'b1 || key_out !== 56'h12_3456_789A_BCDE || match_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL reset_pre_hold: got valid=%b out=%h cnt=%0d, want 1/123456789abcde/1",
               key_out_valid, key_out, match_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    if (key_out_valid !== 1'b0 || key_out !== 56'h0 || match_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_async: got valid=%b out=%h cnt=%0d, want 0/0/0",
               key_out_valid, key_out, match_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_activation();
    logic [55:0] exp_out [3] = '{56'hAB, 56'hAA, 56'hAC};
    logic        exp_act [3] = '{1'b1, 1'b0, 1'b0};
    logic [55:0] keys    [3] = '{56'hAA, 56'hAB, 56'hAC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 56'h0, 1'b1, 32'h5, 1'b1);
      if (match_cnt !== 8'(i + 1) || active !== (i == 2)) begin
        n_err++;
        $display("FAIL act_trig%0d: got cnt=%0d active=%b, want %0d/%b", i, match_cnt, active, i + 1, (i == 2));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, keys[i], 1'b0, 32'h0, 1'b1);
      if (key_out_valid !== 1'b1 || key_out !== exp_out[i] || active !== exp_act[i]) begin
        n_err++;
        $display("FAIL act_key%0d: got valid=%b out=%h active=%b, want 1/%h/%b",
                 i, key_out_valid, key_out, active, exp_out[i], exp_act[i]);
      end
    end
    step(1'b0, 56'h0, 1'b0, 32'h0, 1'b1);
    if (key_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL act_drain: got valid=%b want 0", key_out_valid);
    end
  endtask

  task automatic test_sequence_break();
    logic [31:0] trig [4] = '{32'h5, 32'h5, 32'h7, 32'h5};
    logic [7:0]  cnt  [4] = '{8'd1, 8'd2, 8'd0, 8'd1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 56'h0, 1'b1, trig[i], 1'b1);
      if (match_cnt !== cnt[i] || active !== 1'b0) begin
        n_err++;
        $display("FAIL break_%0d: got cnt=%0d active=%b, want %0d/0", i, match_cnt, active, cnt[i]);
      end
    end
    step(1'b0, 56'h0, 1'b0, 32'h5, 1'b1);
    step(1'b0, 56'h0, 1'b1, 32'h5, 1'b1);
    step(1'b0, 56'h0, 1'b0, 32'h7, 1'b1);
    if (match_cnt !== 8'd2 || active !== 1'b0) begin
      n_err++;
      $display("FAIL gap_hold: got cnt=%0d active=%b, want 2/0", match_cnt, active);
    end
    step(1'b0, 56'h0, 1'b1, 32'h5, 1'b1);
    if (match_cnt !== 8'd3 || active !== 1'b1) begin
      n_err++;
      $display("FAIL gap_activate: got cnt=%0d active=%b, want 3/1", match_cnt, active);
    end
  endtask

  task automatic test_upper_bits();
    do_reset();
    repeat (3) step(1'b0, 56'h0, 1'b1, 32'hFFFF_FFF5, 1'b1);
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL upper_activate: got active=%b want 1", active);
    end
    repeat (2) step(1'b1, 56'h0, 1'b0, 32'h0, 1'b1);
    if (active !== 1'b0 || match_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL upper_exit: got active=%b cnt=%0d, want 0/0", active, match_cnt);
    end
    step(1'b0, 56'h0, 1'b1, 32'h0000_0015, 1'b1);
    if (match_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL upper_15: got cnt=%0d want 1", match_cnt);
    end
    step(1'b0, 56'h0, 1'b1, 32'h0000_0050, 1'b1);
    if (match_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL upper_50: got cnt=%0d want 0", match_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [55:0] k1;
    logic [55:0] k2;
    k1 = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFE;
    k2 = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFE;
    do_reset();
    repeat (3) step(1'b0, 56'h0, 1'b1, 32'h5, 1'b1);
    step(1'b1, k1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, k2 ^ 56'(i + 8), 1'b0, 32'h0, 1'b0);
      if (key_out !== (k1 | 56'h1) || key_out_valid !== 1'b1 || key_ready !== 1'b0 || active !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold%0d: got out=%h valid=%b ready=%b active=%b, want %h/1/0/1",
                 i, key_out, key_out_valid, key_ready, active, k1 | 56'h1);
      end
    end
    step(1'b1, k2, 1'b0, 32'h0, 1'b1);
    if (key_out !== (k2 | 56'h1) || active !== 1'b0) begin
      n_err++;
      $display("FAIL bp_second: got out=%h active=%b, want %h/0", key_out, active, k2 | 56'h1);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    repeat (2) step(1'b0, 56'h0, 1'b1, 32'h5, 1'b1);
    step(1'b1, 56'h10, 1'b1, 32'h5, 1'b1);
    if (key_out !== 56'h10 || active !== 1'b1) begin
      n_err++;
      $display("FAIL same_clean: got out=%h active=%b, want 10/1", key_out, active);
    end
    step(1'b1, 56'h20, 1'b0, 32'h0, 1'b1);
    if (key_out !== 56'h21) begin
      n_err++;
      $display("FAIL same_next: got out=%h want 21", key_out);
    end
    // Last window acceptance coincides with a match: the match is dropped.
    step(1'b1, 56'h30, 1'b1, 32'h5, 1'b1);
    if (key_out !== 56'h31 || active !== 1'b0 || match_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL same_last: got out=%h active=%b cnt=%0d, want 31/0/0", key_out, active, match_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [55:0] k;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      t = $urandom;
      if ($urandom_range(0, 9) < 7) t[3:0] = 4'h5;
      k = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
      step(1'($urandom), k, ($urandom_range(0, 3) != 0), t, ($urandom_range(0, 9) < 7));
      if (key_out_valid !== m_valid || key_out !== m_out || active !== (m_left > 0) ||
          match_cnt !== 8'(m_cnt) || key_ready !== (!m_valid || key_out_ready)) begin
        n_err++;
        $display("FAIL rand_%0d: got v=%b out=%h act=%b cnt=%0d rdy=%b, want %b/%h/%b/%0d/%b",
                 i, key_out_valid, key_out, active, match_cnt, key_ready,
                 m_valid, m_out, (m_left > 0), m_cnt, (!m_valid || key_out_ready));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0; key_in = 56'h0; trig_valid = 1'b0; trigger = 32'h0; key_out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    test_reset();
    test_activation();
    test_sequence_break();
    test_upper_bits();
    test_backpressure();
    test_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
